// File: rtl/cs_y_collector.sv
// Collects CS Y results after window warm-up into a tagged valid/ready FIFO, with flush/clear handshake.
// Optional running max/min statistics are enabled by defining CS_Y_STATS_EN.
module cs_y_collector #(
  parameter int DEPTH  = 4,
  parameter int WARMUP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_en,
  input  logic [9:0] y_in,
  input  logic       flush,
  output logic [9:0] out_data,
  output logic [7:0] out_seq,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       cs_clr,
  output logic [9:0] y_max,
  output logic [9:0] y_min
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WARMUP + 2);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [WW-1:0] WARM_N   = WW'(WARMUP);
  localparam logic [WW-1:0] ONE_W    = WW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  typedef struct packed {
    logic [9:0] y;
    logic [7:0] seq;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic [1:0]      state, state_nx;
  logic [WW-1:0]   wcnt, wcnt_nx;
  logic [7:0]      seq;
  logic            accepted, push_req, push_ok, pop, full, drain_done;

  assign accepted   = in_en && (state != DRAIN);
  assign full       = (count == FULL_CNT);
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign push_ok    = push_req && (!full || pop);
  // A pop that takes the last entry counts as empty, so DRAIN exits in the same cycle.
  assign drain_done = (state == DRAIN) && (!out_valid || (count == ONE_CNT && pop));

  assign head     = mem[rptr];
  assign out_data = out_valid ? head.y   : '0;
  assign out_seq  = out_valid ? head.seq : '0;

  // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    push_req = 1'b0;
    case (state)
      IDLE: begin
        if (accepted) begin
          if (WARMUP == 0) begin
            push_req = 1'b1;
            state_nx = RUN;
          end else begin
            wcnt_nx  = ONE_W;
            state_nx = (WARMUP > 1) ? FILL : RUN;
          end
        end
      end
      FILL: begin
        if (accepted && (wcnt < WARM_N)) wcnt_nx = wcnt + 1'b1;
        if (wcnt_nx == WARM_N) state_nx = RUN;
        if (flush) state_nx = DRAIN;
      end
      RUN: begin
        push_req = accepted;
        if (flush) state_nx = DRAIN;
      end
      default: begin
        if (drain_done) begin
          state_nx = IDLE;
          wcnt_nx  = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wcnt     <= '0;
      seq      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cs_clr   <= 1'b0;
    end else begin
      state  <= state_nx;
      wcnt   <= wcnt_nx;
      cs_clr <= drain_done;
      if (push_req && full && !pop) overflow <= 1'b1;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drain_done)   seq <= '0;
      else if (push_ok) seq <= seq + 1'b1;
    end
  end

  // NOTE: storage is not reset; out_data/out_seq are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= '{y: y_in, seq: seq};
  end

`ifdef CS_Y_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || drain_done) begin
      y_max <= '0;
      y_min <= '1;
    end else if (push_ok) begin
      if (y_in > y_max) y_max <= y_in;
      if (y_in < y_min) y_min <= y_in;
    end
  end
`else
  assign y_max = '0;
  assign y_min = '1;
`endif

endmodule

// File: tb/tb_cs_y_collector.sv
// Scoreboard bench for cs_y_collector: expected {y, seq} queued at stimulus, compared on each pop.
module tb_cs_y_collector;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_en = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [9:0] y_in = '0;
  logic [9:0] out_data, y_max, y_min;
  logic [7:0] out_seq;
  logic       out_valid, overflow, cs_clr;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int clr_pulses = 0;
  logic [17:0] sb [$];
  logic [17:0] exp_e;

  always #5 clk = ~clk;

  cs_y_collector #(.DEPTH(4), .WARMUP(8)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .y_in(y_in), .flush(flush),
    .out_data(out_data), .out_seq(out_seq), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .cs_clr(cs_clr), .y_max(y_max), .y_min(y_min)
  );

  // Pop monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (cs_clr) clr_pulses++;
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop: got y=%0d seq=%0d, required no output", out_data, out_seq);
        end else begin
          exp_e = sb.pop_front();
          if ({out_data, out_seq} !== exp_e) begin
            errors++;
            $display("FAIL pop_data: got y=%0d seq=%0d, required y=%0d seq=%0d",
                     out_data, out_seq, exp_e[17:8], exp_e[7:0]);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [9:0] y, input bit push, input logic [7:0] s);
    in_en = 1'b1;
    y_in  = y;
    if (push) sb.push_back({y, s});
    cyc();
    in_en = 1'b0;
  endtask

  task automatic warm(input int base);
    for (int i = 0; i < 8; i++) sample(10'(base + i), 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    sb.delete();
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d entries outstanding, required 0", sb.size());
      sb.delete();
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    checks++; if (cs_clr !== 1'b0) begin errors++; $display("FAIL rst_cs_clr: got %b, required 0", cs_clr); end
    checks++; if (out_data !== 10'd0) begin errors++; $display("FAIL rst_out_data: got %0h, required 0", out_data); end
    checks++; if (out_seq !== 8'd0) begin errors++; $display("FAIL rst_out_seq: got %0h, required 0", out_seq); end
    checks++; if (y_max !== 10'd0) begin errors++; $display("FAIL rst_y_max: got %0h, required 0", y_max); end
    checks++; if (y_min !== 10'h3FF) begin errors++; $display("FAIL rst_y_min: got %0h, required 3ff", y_min); end
  endtask

  task automatic test_warmup();
    do_reset();
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 12; i++) sample(10'(100 + i), i >= 8, 8'(i - 8));
    wait_drain();
    checks++; if (pops != 4) begin errors++; $display("FAIL warmup_pops: got %0d, required 4", pops); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    warm(0);
    for (int i = 0; i < 6; i++) sample(10'(200 + i), i < 4, 8'(i));
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b, required 1", out_valid); end
    cyc(); cyc();
    checks++; if (out_data !== 10'd200) begin errors++; $display("FAIL ovf_head_stable: got %0d, required 200", out_data); end
    pops = 0;
    out_ready = 1'b1;
    wait_drain();
    checks++; if (pops != 4) begin errors++; $display("FAIL ovf_pops: got %0d, required 4", pops); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    warm(0);
    for (int i = 0; i < 4; i++) sample(10'(200 + i), 1'b1, 8'(i));
    out_ready = 1'b1;
    sample(10'd300, 1'b1, 8'd4);
    out_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_overflow: got %b, required 0", overflow); end
    sample(10'd301, 1'b0, 8'd0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fpp_still_full: got %b, required 1", overflow); end
    pops = 0;
    out_ready = 1'b1;
    wait_drain();
    checks++; if (pops != 4) begin errors++; $display("FAIL fpp_pops: got %0d, required 4", pops); end
    sample(10'd302, 1'b1, 8'd5);
    wait_drain();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    warm(0);
    for (int i = 0; i < 3; i++) sample(10'(500 + i), 1'b1, 8'(i));
    pops = 0;
    clr_pulses = 0;
    flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    sample(10'd999, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (pops != 3) begin errors++; $display("FAIL flush_pops: got %0d, required 3", pops); end
    checks++; if (clr_pulses != 1) begin errors++; $display("FAIL flush_clr_pulses: got %0d, required 1", clr_pulses); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b, required 0", out_valid); end
    warm(400);
    sample(10'd408, 1'b1, 8'd0);
    wait_drain();
    // Empty FIFO in RUN: cs_clr appears two cycles after flush is sampled.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (cs_clr !== 1'b0) begin errors++; $display("FAIL flush_clr_early: got %b, required 0", cs_clr); end
    cyc();
    checks++; if (cs_clr !== 1'b1) begin errors++; $display("FAIL flush_clr_timing: got %b, required 1", cs_clr); end
    cyc();
    checks++; if (cs_clr !== 1'b0) begin errors++; $display("FAIL flush_clr_width: got %b, required 0", cs_clr); end
    warm(700);
    sample(10'd708, 1'b1, 8'd0);
    wait_drain();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    warm(0);
    for (int i = 0; i < 5; i++) sample(10'(600 + i), i < 4, 8'(i));
    out_ready = 1'b1;
    cyc(); cyc();
    out_ready = 1'b0;
    checks++; if (sb.size() != 2) begin errors++; $display("FAIL mid_held: got %0d entries, required 2", sb.size()); end
    sb.delete();
    reset = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b, required 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b, required 0", overflow); end
    reset = 1'b0;
    out_ready = 1'b1;
    warm(800);
    sample(10'd808, 1'b1, 8'd0);
    wait_drain();
    out_ready = 1'b0;
  endtask

  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    warm(10);
    sample(10'd50, 1'b1, 8'd0);
    sample(10'd900, 1'b1, 8'd1);
    sample(10'd3, 1'b1, 8'd2);
`ifdef CS_Y_STATS_EN
    checks++; if (y_max !== 10'd900) begin errors++; $display("FAIL stats_max: got %0d, required 900", y_max); end
    checks++; if (y_min !== 10'd3) begin errors++; $display("FAIL stats_min: got %0d, required 3", y_min); end
`else
    checks++; if (y_max !== 10'd0) begin errors++; $display("FAIL stats_max_tied: got %0d, required 0", y_max); end
    checks++; if (y_min !== 10'h3FF) begin errors++; $display("FAIL stats_min_tied: got %0h, required 3ff", y_min); end
`endif
    wait_drain();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (y_max !== 10'd0) begin errors++; $display("FAIL stats_max_clr: got %0d, required 0", y_max); end
    checks++; if (y_min !== 10'h3FF) begin errors++; $display("FAIL stats_min_clr: got %0h, required 3ff", y_min); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_y_collector.md
# cs_y_collector

Downstream consumer of the CS computational stage. Samples the CS 10-bit `Y` result on each rising edge where the current input sample is marked valid, and discards the warm-up results produced while the 9-sample window is still filling. Pushes valid results, tagged with a sequence number, into a small FIFO with a valid/ready output. Supports a flush sequence that drains the FIFO and pulses a clear request back to CS.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `WARMUP`, 8: number of leading samples whose results are discarded after IDLE.
- `clk` in 1: clock. All state updates on rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `in_en` in 1: the X presented to CS during this cycle is a real sample.
- `y_in` in 10: CS `Y`. CS updates it on the falling edge, so it is stable at the next rising edge.
- `flush` in 1: request to drain the FIFO and restart the window.
- `out_data` out 10: Y value at the FIFO head.
- `out_seq` out 8: sequence number at the FIFO head.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head this cycle.
- `overflow` out 1: sticky; a result was dropped because the FIFO was full.
- `cs_clr` out 1: one-cycle pulse requesting a CS window clear. Integrator ORs it into the CS reset.
- `y_max`, `y_min` out 10 each: running statistics over pushed results (see Configuration).

## Operation
- **Capture**
  - At a rising edge with `in_en`=1, `y_in` is the CS result for the sample presented in the cycle just ended.
  - That sample is "accepted" when the state is IDLE, FILL or RUN.
- **FSM states:** IDLE, FILL, RUN, DRAIN. Reset state is IDLE.
- **IDLE**
  - Accepted sample with WARMUP=0: push the result, go to RUN.
  - Accepted sample with WARMUP>0: discard the result, set `wcnt`=1, go to FILL if WARMUP>1, otherwise go to RUN.
  - `flush` is ignored.
- **FILL**
  - Accepted sample with `wcnt`<WARMUP: discard the result and increment `wcnt`.
  - Go to RUN when `wcnt` reaches WARMUP.
  - The first push is the result of sample WARMUP+1.
- **RUN**
  - Every accepted sample is pushed.
- **Flush**
  - `flush` in FILL or RUN goes to DRAIN.
  - A sample accepted in the same cycle is still handled per the current state (pushed in RUN).
- **DRAIN**
  - `in_en` is ignored: no push, no overflow.
  - When the FIFO is empty (including a pop emptying it this cycle), go to IDLE, clear `wcnt` and the sequence counter, and assert `cs_clr` for exactly the next cycle.
- **Push**
  - Writes {`y_in`, `seq`}, then `seq` increments, wrapping 255→0.
  - `seq` resets to 0.
- **Pop**
  - Occurs when `out_valid` && `out_ready`.
- **Full FIFO**
  - A push with a simultaneous pop is accepted.
  - A push without a pop is dropped, `overflow` is set, and `seq` does not increment.
- **Empty FIFO**
  - `out_ready` has no effect.
  - A push into an empty FIFO appears on the outputs in the next cycle. There is no bypass.
- **Pointers and count**
  - Read/write pointers are log2(DEPTH) bits wide and wrap naturally.
  - Count is log2(DEPTH)+1 bits.
- **Reset** (also when asserted mid-operation) clears state, pointers, count, `seq`, `wcnt` and `overflow`.

## Timing
- Latency: a sample valid in cycle n yields `out_valid`=1 in cycle n+1 if the FIFO was empty.
- Sustained throughput: one push and one pop per cycle.
- `out_data`/`out_seq` are stable while `out_valid`=1 and `out_ready`=0.
- Reset values:
  - `out_valid`=0, `overflow`=0, `cs_clr`=0.
  - `out_data`=0, `out_seq`=0.
  - `y_max`=0, `y_min`=10'h3FF.
- `cs_clr` is high for one cycle, the cycle after the DRAIN→IDLE edge.
- With an empty FIFO, `flush` in RUN produces `cs_clr` two cycles after `flush` is sampled.

## Configuration
- Macro: `CS_Y_STATS_EN`.
- Defined:
  - On each accepted push, `y_max`←max(`y_max`,`y_in`) and `y_min`←min(`y_min`,`y_in`).
  - Both reinitialise to 0 / 10'h3FF on the DRAIN→IDLE edge and on reset.
- Undefined: `y_max` is tied to 0 and `y_min` to 10'h3FF, and no comparator logic is generated.

## Test plan
- **Warm-up:** reset, then 12 consecutive `in_en` with `y_in`=100..111 and `out_ready`=1 → exactly 4 pops, data 108..111, `seq` 0..3, no pops earlier.
- **Overflow:** DEPTH=4, RUN state, `out_ready`=0, 6 pushes of 200..205 → FIFO holds 200..203, `overflow`=1. Then `out_ready`=1 → pops 200..203, `seq` 0..3.
- **Full push+pop:** FIFO full, push 300 with simultaneous pop → accepted, no overflow, count stays 4.
- **Flush with data:** flush in RUN with 3 entries, `out_ready`=1 → 3 pops, then a single-cycle `cs_clr`; a subsequent 9th sample gives `seq`=0; `in_en` during DRAIN is ignored.
- **Reset mid-stream:** reset with 2 entries held → next cycle `out_valid`=0, `overflow`=0, state IDLE.
- **CS_Y_STATS_EN:** pushes 50, 900, 3 → `y_max`=900, `y_min`=3; after a flush → 0 / 10'h3FF.
